// File: rtl/wb_buf_pkg.sv
// Shared memory-interface types for the write-back buffer and its neighbours.
package wb_buf_pkg;

    localparam int XLEN    = 32;
    localparam int OFF_LEN = 2;

    typedef logic bool;
    localparam bool TRUE  = 1'b1;
    localparam bool FALSE = 1'b0;

    typedef logic [XLEN-1:0]       mem_blk_t;
    typedef logic [XLEN-OFF_LEN-1:0] mem_idx_t;
    typedef logic [3:0]            mem_tag_t;

    typedef enum logic [1:0] {
        MEM_CMD_NONE  = 2'd0,
        MEM_CMD_LOAD  = 2'd1,
        MEM_CMD_STORE = 2'd2
    } mem_cmd_t;

endpackage

// File: rtl/wb_buf.sv
// Victim buffer: queues evicted blocks, drains them oldest-first as stores,
// merges re-evictions and answers same-cycle miss lookups.
module wb_buf
    import wb_buf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     evict_valid,
    input  mem_idx_t                 evict_idx,
    input  mem_blk_t                 evict_blk,
    output logic                     evict_ready,
    input  logic                     lkup_valid,
    input  mem_idx_t                 lkup_idx,
    output logic                     lkup_hit,
    output mem_blk_t                 lkup_blk,
    output mem_cmd_t                 mem_qry_cmd,
    output mem_idx_t                 mem_qry_idx,
    output mem_blk_t                 mem_qry_blk,
    input  mem_tag_t                 mem_ack,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic     valid;
        mem_idx_t idx;
        mem_blk_t blk;
    } wb_entry_t;

    wb_entry_t       entries     [DEPTH];
    wb_entry_t       entries_nxt [DEPTH];
    logic [PW-1:0]   head, head_nxt, tail, tail_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    bool             push, pop, merge_hit;
    logic [PW-1:0]   merge_sel;

    assign evict_ready = (cnt != CW'(DEPTH));
    assign push        = evict_valid && evict_ready;
    assign pop         = (cnt != '0) && (mem_ack != '0);
    assign count       = cnt;

    // The popping head is excluded from merging so its data still leaves with the old store.
    always_comb begin
        merge_hit = FALSE;
        merge_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries[i].valid && entries[i].idx == evict_idx
                && !(pop && head == PW'(i))) begin
                merge_hit = TRUE;
                merge_sel = PW'(i);
            end
        end

        entries_nxt = entries;
        head_nxt    = head;
        tail_nxt    = tail;
        cnt_nxt     = cnt;

        if (pop) begin
            entries_nxt[head].valid = 1'b0;
            head_nxt                = head + 1'b1;
            cnt_nxt                 = cnt_nxt - CW'(1);
        end
        if (push) begin
            if (merge_hit) begin
                entries_nxt[merge_sel].blk = evict_blk;
            end else begin
                entries_nxt[tail] = '{valid: 1'b1, idx: evict_idx, blk: evict_blk};
                tail_nxt          = tail + 1'b1;
                cnt_nxt           = cnt_nxt + CW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            head <= head_nxt;
            tail <= tail_nxt;
            cnt  <= cnt_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= entries_nxt[i];
            end
        end
    end

    // Lookup sees registered state only; merging keeps matches unique.
    always_comb begin
        lkup_hit = 1'b0;
        lkup_blk = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (lkup_valid && entries[i].valid && entries[i].idx == lkup_idx) begin
                lkup_hit = 1'b1;
                lkup_blk = entries[i].blk;
            end
        end
    end

    always_comb begin
        mem_qry_cmd = MEM_CMD_NONE;
        mem_qry_idx = '0;
        mem_qry_blk = '0;
        if (cnt != '0) begin
            mem_qry_cmd = MEM_CMD_STORE;
            mem_qry_idx = entries[head].idx;
            mem_qry_blk = entries[head].blk;
        end
    end

endmodule
